cgp_fitness_eval: RTL and testbench

Synthesizable fitness evaluator for one 4-input, 1-output CGP candidate circuit. It sweeps every input pattern into the candidate, waits a fixed settle time, samples the candidate's output, and counts matches against the reference function (4-input parity). It sits between the evolution controller and the candidate under test, so fitness scoring runs on-chip without a simulator.

---
 rtl/cgp_eval_pkg.sv | 34 +++
 rtl/cgp_eval_ref.sv | 17 +
 rtl/cgp_fitness_eval.sv | 97 +++++++++
 tb/tb_cgp_fitness_eval.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cgp_eval_pkg.sv
// Shared types, defaults and the reference target function for the CGP fitness evaluator.
// Width helpers let each evaluator derive its counter sizes from its own N_IN/SETTLE.
package cgp_eval_pkg;

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_DRIVE = 1'b1
  } state_t;

  localparam int DEF_N_IN   = 4;
  localparam int DEF_SETTLE = 2;
  localparam int MAX_N_IN   = 16;

  function automatic int sweep_len(input int n_in);
    return 1 << n_in;
  endfunction

  localparam int DEF_SWEEP_LEN = 1 << DEF_N_IN;

  // Settle counter must hold SETTLE itself; keep at least one bit when SETTLE is 0.
  function automatic int settle_cnt_w(input int settle);
    int w;
    w = $clog2(settle + 1);
    return (w < 1) ? 1 : w;
  endfunction

  localparam int DEF_SETTLE_W = (DEF_SETTLE < 1) ? 1 : $clog2(DEF_SETTLE + 1);

  // Patterns narrower than MAX_N_IN are zero-extended, which leaves parity unchanged.
  function automatic logic parity_ref(input logic [MAX_N_IN-1:0] pattern);
    return ^pattern;
  endfunction

endpackage

// File: rtl/cgp_eval_ref.sv
// Combinational reference: the bit the candidate is expected to produce for the
// current stimulus pattern. Swap the function here to score against another target.
module cgp_eval_ref
  import cgp_eval_pkg::*;
#(
  parameter int N_IN = DEF_N_IN
) (
  input  logic [N_IN-1:0] pattern,
  output logic            expected
);

  logic [MAX_N_IN-1:0] pattern_ext;

  assign pattern_ext = MAX_N_IN'(pattern);
  assign expected    = parity_ref(pattern_ext);

endmodule

// File: rtl/cgp_fitness_eval.sv
// Sweeps every input pattern into a candidate circuit, holds each for SETTLE+1 cycles,
// samples the candidate output on the last edge and counts matches against the reference.
module cgp_fitness_eval
  import cgp_eval_pkg::*;
#(
  parameter int N_IN   = DEF_N_IN,
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            abort,
  input  logic            cand_out,
  output logic [N_IN-1:0] pattern,
  output logic            busy,
  output logic            done,
  output logic [N_IN:0]   score,
  output logic [N_IN:0]   total
);

  localparam int CNT_W = settle_cnt_w(SETTLE);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [N_IN-1:0]  PAT_LAST    = '1;
  localparam logic [N_IN-1:0]  PAT_ONE     = N_IN'(1);
  localparam logic [N_IN:0]    ACC_ONE     = (N_IN + 1)'(1);

  state_t           state_reg;
  logic [CNT_W-1:0] settle_reg;
  logic             expected;

  cgp_eval_ref #(
    .N_IN(N_IN)
  ) u_ref (
    .pattern (pattern),
    .expected(expected)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      settle_reg <= '0;
      pattern    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      score      <= '0;
      total      <= '0;
    end else begin
      done <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            state_reg  <= ST_DRIVE;
            pattern    <= '0;
            settle_reg <= SETTLE_LOAD;
            score      <= '0;
            total      <= '0;
            busy       <= 1'b1;
          end
        end

        ST_DRIVE: begin
          if (abort) begin
            state_reg <= ST_IDLE;
            busy      <= 1'b0;
            pattern   <= '0;
          end else if (settle_reg != '0) begin
            settle_reg <= settle_reg - CNT_ONE;
          end else begin
            total <= total + ACC_ONE;
            // An unknown candidate output makes this comparison false: a mismatch.
            if (cand_out == expected) begin
              score <= score + ACC_ONE;
            end
            if (pattern == PAT_LAST) begin
              state_reg <= ST_IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              pattern   <= '0;
            end else begin
              pattern    <= pattern + PAT_ONE;
              settle_reg <= SETTLE_LOAD;
            end
          end
        end

        default: begin
          state_reg <= ST_IDLE;
          busy      <= 1'b0;
          pattern   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cgp_fitness_eval.sv
// Directed bench for cgp_fitness_eval: three builds (SETTLE=2, 0, 5) driven by
// behavioural candidates selected per test.
module tb_cgp_fitness_eval;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic abort = 1'b0;

  logic start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;
  logic cand_a, cand_b, cand_c;
  logic [3:0] pattern_a, pattern_b, pattern_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [4:0] score_a, score_b, score_c;
  logic [4:0] total_a, total_b, total_c;

  int mode_a = 0;
  int mode_b = 0;
  logic dly_b;

  int total_cnt = 0;
  int bad_cnt   = 0;

  always #5 clk = ~clk;

  // Candidate models: 0 parity, 1 constant 0, 2 pattern[0], 3 inverted parity.
  always_comb begin
    cand_a = ^pattern_a;
    case (mode_a)
      1:       cand_a = 1'b0;
      2:       cand_a = pattern_a[0];
      3:       cand_a = ~(^pattern_a);
      default: cand_a = ^pattern_a;
    endcase
  end

  // Build B candidate: parity, or parity delayed by one register stage.
  always_ff @(posedge clk) dly_b <= ^pattern_b;
  assign cand_b = (mode_b == 1) ? dly_b : ^pattern_b;
  assign cand_c = ^pattern_c;

  cgp_fitness_eval #(.N_IN(4), .SETTLE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort), .cand_out(cand_a),
    .pattern(pattern_a), .busy(busy_a), .done(done_a), .score(score_a), .total(total_a)
  );

  cgp_fitness_eval #(.N_IN(4), .SETTLE(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort), .cand_out(cand_b),
    .pattern(pattern_b), .busy(busy_b), .done(done_b), .score(score_b), .total(total_b)
  );

  cgp_fitness_eval #(.N_IN(4), .SETTLE(5)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(start_c), .abort(abort), .cand_out(cand_c),
    .pattern(pattern_c), .busy(busy_c), .done(done_c), .score(score_c), .total(total_c)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Pulse start on one build, then count edges after E0 until done (bounded).
  task automatic run_sweep(input int which, output int cycles, output int busyc,
                           output int sc, output int tot);
    logic d, b;
    case (which)
      1:       start_b = 1'b1;
      2:       start_c = 1'b1;
      default: start_a = 1'b1;
    endcase
    step();
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    cycles = 0;
    busyc  = (which == 1) ? int'(busy_b) : (which == 2) ? int'(busy_c) : int'(busy_a);
    for (int i = 0; i < 400; i++) begin
      step();
      cycles++;
      d = (which == 1) ? done_b : (which == 2) ? done_c : done_a;
      b = (which == 1) ? busy_b : (which == 2) ? busy_c : busy_a;
      if (d) break;
      busyc += int'(b);
    end
    sc  = (which == 1) ? int'(score_b) : (which == 2) ? int'(score_c) : int'(score_a);
    tot = (which == 1) ? int'(total_b) : (which == 2) ? int'(total_c) : int'(total_a);
    $display("sweep build=%0d cycles=%0d busy_cycles=%0d score=%0d total=%0d",
             which, cycles, busyc, sc, tot);
  endtask

  task automatic test_reset();
    total_cnt++;
    if ({busy_a, done_a, pattern_a, score_a, total_a} !== 16'h0) begin
      bad_cnt++;
      $display("FAIL reset_state: busy=%b done=%b pattern=%h score=%0d total=%0d required all 0",
               busy_a, done_a, pattern_a, score_a, total_a);
    end
    rst_n = 1'b1;
    step();
    step();
    total_cnt++;
    if (busy_a !== 1'b0 || done_a !== 1'b0) begin
      bad_cnt++;
      $display("FAIL idle_after_reset: busy=%b done=%b required 0 0", busy_a, done_a);
    end
    $display("reset checked");
  endtask

  task automatic test_parity();
    int cyc, bc, sc, tot;
    mode_a = 0;
    run_sweep(0, cyc, bc, sc, tot);
    total_cnt++;
    if (cyc !== 48) begin bad_cnt++; $display("FAIL parity_done_time: got %0d required 48", cyc); end
    total_cnt++;
    if (bc !== 48) begin bad_cnt++; $display("FAIL parity_busy_len: got %0d required 48", bc); end
    total_cnt++;
    if (sc !== 16 || tot !== 16) begin
      bad_cnt++; $display("FAIL parity_score: score=%0d total=%0d required 16 16", sc, tot);
    end
    total_cnt++;
    if (busy_a !== 1'b0 || pattern_a !== 4'h0) begin
      bad_cnt++; $display("FAIL parity_end_state: busy=%b pattern=%h required 0 0", busy_a, pattern_a);
    end
    step();
    total_cnt++;
    if (done_a !== 1'b0 || score_a !== 5'd16) begin
      bad_cnt++; $display("FAIL done_one_cycle: done=%b score=%0d required 0 16", done_a, score_a);
    end
  endtask

  task automatic test_candidates();
    int cyc, bc, sc, tot;
    int modes[3] = '{1, 2, 3};
    int exp_sc[3] = '{8, 8, 0};
    for (int k = 0; k < 3; k++) begin
      mode_a = modes[k];
      run_sweep(0, cyc, bc, sc, tot);
      total_cnt++;
      if (sc !== exp_sc[k] || tot !== 16 || cyc !== 48) begin
        bad_cnt++;
        $display("FAIL cand_mode%0d: score=%0d total=%0d cycles=%0d required %0d 16 48",
                 modes[k], sc, tot, cyc, exp_sc[k]);
      end
      step();
    end
    mode_a = 0;
  endtask

  task automatic test_settle();
    int cyc, bc, sc, tot;
    mode_b = 0;
    run_sweep(1, cyc, bc, sc, tot);
    total_cnt++;
    if (cyc !== 16 || sc !== 16 || tot !== 16) begin
      bad_cnt++; $display("FAIL settle0: cycles=%0d score=%0d total=%0d required 16 16 16", cyc, sc, tot);
    end
    step();
    run_sweep(2, cyc, bc, sc, tot);
    total_cnt++;
    if (cyc !== 96 || sc !== 16 || tot !== 16) begin
      bad_cnt++; $display("FAIL settle5: cycles=%0d score=%0d total=%0d required 96 16 16", cyc, sc, tot);
    end
    step();
    // Delayed candidate sees the previous pattern's parity: matches at p=0,2,6,8,10,14.
    mode_b = 1;
    run_sweep(1, cyc, bc, sc, tot);
    total_cnt++;
    if (sc !== 6 || tot !== 16) begin
      bad_cnt++; $display("FAIL settle0_delayed: score=%0d total=%0d required 6 16", sc, tot);
    end
    mode_b = 0;
    step();
  endtask

  task automatic test_abort();
    int cyc, bc, sc, tot;
    start_a = 1'b1; step(); start_a = 1'b0;     // E0
    for (int i = 0; i < 9; i++) step();         // through E0+9
    abort = 1'b1; step(); abort = 1'b0;         // E0+10
    total_cnt++;
    if (busy_a !== 1'b0 || done_a !== 1'b0 || pattern_a !== 4'h0) begin
      bad_cnt++; $display("FAIL abort_state: busy=%b done=%b pattern=%h required 0 0 0",
                          busy_a, done_a, pattern_a);
    end
    total_cnt++;
    if (total_a !== 5'd3 || score_a !== 5'd3) begin
      bad_cnt++; $display("FAIL abort_partial: score=%0d total=%0d required 3 3", score_a, total_a);
    end
    cyc = 0;
    for (int i = 0; i < 60; i++) begin step(); cyc += int'(done_a) + int'(busy_a); end
    total_cnt++;
    if (cyc !== 0) begin bad_cnt++; $display("FAIL abort_no_done: activity=%0d required 0", cyc); end
    // Abort coinciding with the first sample edge wins over the sample.
    start_a = 1'b1; step(); start_a = 1'b0;
    step(); step();
    abort = 1'b1; step(); abort = 1'b0;
    total_cnt++;
    if (total_a !== 5'd0 || busy_a !== 1'b0) begin
      bad_cnt++; $display("FAIL abort_priority: total=%0d busy=%b required 0 0", total_a, busy_a);
    end
    run_sweep(0, cyc, bc, sc, tot);
    total_cnt++;
    if (sc !== 16 || cyc !== 48) begin
      bad_cnt++; $display("FAIL after_abort_sweep: score=%0d cycles=%0d required 16 48", sc, cyc);
    end
    step();
  endtask

  task automatic test_start_ignored();
    int cyc;
    start_a = 1'b1; step(); start_a = 1'b0;
    cyc = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      cyc++;
      start_a = (cyc == 20);
      if (done_a) break;
    end
    start_a = 1'b0;
    $display("start_ignored cycles=%0d score=%0d", cyc, score_a);
    total_cnt++;
    if (cyc !== 48 || score_a !== 5'd16) begin
      bad_cnt++; $display("FAIL start_ignored: cycles=%0d score=%0d required 48 16", cyc, score_a);
    end
    step();
  endtask

  task automatic test_back_to_back();
    int cyc, bc, sc, tot;
    run_sweep(0, cyc, bc, sc, tot);
    start_a = 1'b1; step(); start_a = 1'b0;    // start sampled during the done cycle
    total_cnt++;
    if (busy_a !== 1'b1 || score_a !== 5'd0 || total_a !== 5'd0 || pattern_a !== 4'h0) begin
      bad_cnt++; $display("FAIL b2b_restart: busy=%b score=%0d total=%0d pattern=%h required 1 0 0 0",
                          busy_a, score_a, total_a, pattern_a);
    end
    cyc = 0;
    for (int i = 0; i < 200; i++) begin step(); cyc++; if (done_a) break; end
    $display("back_to_back cycles=%0d score=%0d", cyc, score_a);
    total_cnt++;
    if (cyc !== 48 || score_a !== 5'd16) begin
      bad_cnt++; $display("FAIL b2b_second: cycles=%0d score=%0d required 48 16", cyc, score_a);
    end
    step();
  endtask

  task automatic test_start_abort_idle();
    start_a = 1'b1; abort = 1'b1; step(); start_a = 1'b0; abort = 1'b0;
    total_cnt++;
    if (busy_a !== 1'b1) begin bad_cnt++; $display("FAIL start_over_abort: busy=%b required 1", busy_a); end
    abort = 1'b1; step(); abort = 1'b0;
    total_cnt++;
    if (busy_a !== 1'b0) begin bad_cnt++; $display("FAIL abort_cleanup: busy=%b required 0", busy_a); end
    $display("start_abort_idle checked");
  endtask

  task automatic test_reset_mid();
    int act;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int i = 0; i < 20; i++) step();
    #2 rst_n = 1'b0;
    #1;
    total_cnt++;
    if ({busy_a, done_a, pattern_a, score_a, total_a} !== 16'h0) begin
      bad_cnt++; $display("FAIL async_reset: busy=%b done=%b pattern=%h score=%0d total=%0d required all 0",
                          busy_a, done_a, pattern_a, score_a, total_a);
    end
    step();
    rst_n = 1'b1;
    act = 0;
    for (int i = 0; i < 60; i++) begin step(); act += int'(done_a) + int'(busy_a); end
    total_cnt++;
    if (act !== 0) begin bad_cnt++; $display("FAIL post_reset_idle: activity=%0d required 0", act); end
    $display("reset_mid checked");
  endtask

  initial begin
    step();
    step();
    test_reset();
    test_parity();
    test_candidates();
    test_settle();
    test_abort();
    test_start_ignored();
    test_back_to_back();
    test_start_abort_idle();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
